// File: rtl/mem_access_sequencer_if.sv
// Bundle of core-side request/response, memory-port and UART signals for mem_access_sequencer.
interface mem_access_sequencer_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        uart_wr;
    logic [7:0]  uart_data;
    logic        uart_busy;

    // Sequencer side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
               mem_rdata, uart_busy,
        output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, d_err,
               mem_en, mem_we, mem_addr, mem_wdata, uart_wr, uart_data
    );

    // Core / memory / UART side
    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
               mem_rdata, uart_busy,
        input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, d_err,
               mem_en, mem_we, mem_addr, mem_wdata, uart_wr, uart_data
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Shares one sync memory port between fetch and load/store, diverts UART_ADDR traffic; response MEM_LATENCY+1 cycles after grant,
// grants only in IDLE (requests must be held), UART stores stall on uart_busy. MISALIGN_TRAP_EN traps misaligned data accesses.
module mem_access_sequencer #(
    parameter int          MEM_LATENCY = 1,
    parameter logic [31:0] UART_ADDR   = 32'h0002_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_access_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ACCESS, WAIT, UART, DONE} state_t;
    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    state_t      state, state_nxt;
    logic        is_data_q, we_q, uns_q, d_err_q;
    logic [1:0]  size_q;
    logic [2:0]  cnt_q;
    logic [3:0]  mem_we_q;
    logic [7:0]  uart_byte_q;
    logic [31:0] addr_q, mem_wdata_q, if_rdata_q, d_rdata_q;

    logic        grant_d, grant_i, trap, to_uart;
    logic [31:0] eff_addr, lane_wdata;
    logic [3:0]  lane_we;
    logic        d_set, d_err_res, i_set, uart_wr_c;
    logic [31:0] d_res;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                            input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    assign grant_d = !rst && (state == IDLE) && bus.d_req;
    assign grant_i = !rst && (state == IDLE) && !bus.d_req && bus.if_req;
    assign to_uart = (bus.d_addr == UART_ADDR);

    always_comb begin
        eff_addr = bus.d_addr;
`ifdef MISALIGN_TRAP_EN
        trap = (bus.d_size == 2'b01 && bus.d_addr[0]) ||
               (bus.d_size[1] && bus.d_addr[1:0] != 2'b00);
`else
        // Without trapping, misaligned accesses silently round down to natural alignment
        trap = 1'b0;
        if (bus.d_size == 2'b01)
            eff_addr[0] = 1'b0;
        else if (bus.d_size[1])
            eff_addr[1:0] = 2'b00;
`endif
        case (bus.d_size)
            2'b00: begin
                lane_we    = 4'b0001 << eff_addr[1:0];
                lane_wdata = {4{bus.d_wdata[7:0]}};
            end
            2'b01: begin
                lane_we    = 4'b0011 << {eff_addr[1], 1'b0};
                lane_wdata = {2{bus.d_wdata[15:0]}};
            end
            default: begin
                lane_we    = 4'b1111;
                lane_wdata = bus.d_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        d_set     = 1'b0;
        d_res     = 32'h0;
        d_err_res = 1'b0;
        i_set     = 1'b0;
        uart_wr_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_d) begin
                    if (trap) begin
                        state_nxt = DONE;
                        d_set     = 1'b1;
                        d_err_res = 1'b1;
                    end else if (to_uart) begin
                        state_nxt = UART;
                    end else begin
                        state_nxt = ACCESS;
                    end
                end else if (grant_i) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS, WAIT: begin
                if (state == ACCESS && is_data_q && we_q) begin
                    state_nxt = DONE;
                    d_set     = 1'b1;
                end else if ((state == ACCESS && LAT <= 3'd1) || (state == WAIT && cnt_q >= LAT)) begin
                    state_nxt = DONE;
                    d_set     = is_data_q;
                    i_set     = !is_data_q;
                    d_res     = extract(bus.mem_rdata, addr_q[1:0], size_q, uns_q);
                end else begin
                    state_nxt = WAIT;
                end
            end
            UART: begin
                if (!we_q) begin
                    state_nxt = DONE;
                    d_set     = 1'b1;
                    d_res     = {31'h0, bus.uart_busy};
                end else if (!bus.uart_busy) begin
                    state_nxt = DONE;
                    d_set     = 1'b1;
                    uart_wr_c = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_data_q   <= 1'b0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= 32'h0;
            uart_byte_q <= 8'h0;
            mem_we_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
            cnt_q       <= 3'd0;
            d_rdata_q   <= 32'h0;
            d_err_q     <= 1'b0;
            if_rdata_q  <= 32'h0;
        end else begin
            if (grant_d) begin
                is_data_q   <= 1'b1;
                we_q        <= bus.d_we;
                uns_q       <= bus.d_unsigned;
                size_q      <= bus.d_size;
                addr_q      <= eff_addr;
                uart_byte_q <= bus.d_wdata[7:0];
                mem_we_q    <= bus.d_we ? lane_we : 4'h0;
                mem_wdata_q <= bus.d_we ? lane_wdata : 32'h0;
            end else if (grant_i) begin
                is_data_q   <= 1'b0;
                we_q        <= 1'b0;
                uns_q       <= 1'b0;
                size_q      <= 2'b10;
                addr_q      <= bus.if_addr;
                mem_we_q    <= 4'h0;
                mem_wdata_q <= 32'h0;
            end
            // cnt_q tracks the cycle index since grant while waiting on memory
            if (state == ACCESS)
                cnt_q <= 3'd2;
            else if (state == WAIT)
                cnt_q <= cnt_q + 3'd1;
            if (d_set) begin
                d_rdata_q <= d_res;
                d_err_q   <= d_err_res;
            end
            if (i_set)
                if_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.if_gnt    = grant_i;
    assign bus.d_gnt     = grant_d;
    assign bus.mem_en    = !rst && (state == ACCESS);
    assign bus.mem_we    = bus.mem_en ? mem_we_q : 4'h0;
    assign bus.mem_addr  = bus.mem_en ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus.mem_wdata = bus.mem_en ? mem_wdata_q : 32'h0;
    assign bus.uart_wr   = !rst && uart_wr_c;
    assign bus.uart_data = bus.uart_wr ? uart_byte_q : 8'h0;
    assign bus.if_valid  = !rst && (state == DONE) && !is_data_q;
    assign bus.d_valid   = !rst && (state == DONE) && is_data_q;
    assign bus.if_rdata  = rst ? 32'h0 : if_rdata_q;
    assign bus.d_rdata   = rst ? 32'h0 : d_rdata_q;
    assign bus.d_err     = !rst && d_err_q;
endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Multicycle memory-access sequencer for the RISC-V core. It shares the single synchronous memory port between instruction fetch and data load/store, and intercepts stores and loads to the UART address. It also generates byte-lane write masks and sign- or zero-extends load data. It sits between the core controller and the memory/UART and returns one response per granted request.

## Interface
- `MEM_LATENCY`, default 1: cycles from `mem_en` to valid `mem_rdata` (1–4).
- `UART_ADDR`, default 32'h00020000: byte address of the UART data/status register.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `if_req` in 1: fetch request; held until `if_gnt`.
- `if_addr` in 32: fetch byte address; bits [1:0] ignored.
- `if_gnt` out 1: fetch accepted (combinational, IDLE only).
- `if_valid` out 1: one-cycle pulse; `if_rdata` valid.
- `if_rdata` out 32: fetched instruction word.
- `d_req` in 1: data request; held until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `d_unsigned` in 1: zero-extend loads when 1.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data, right-aligned.
- `d_gnt` out 1: data request accepted (combinational, IDLE only).
- `d_valid` out 1: one-cycle completion pulse.
- `d_rdata` out 32: extended load data; 0 for stores.
- `d_err` out 1: misaligned access, valid with `d_valid`.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 4: byte write mask; 0000 for reads.
- `mem_addr` out 32: word address, bits [1:0] = 00.
- `mem_wdata` out 32: lane-positioned store data.
- `mem_rdata` in 32: memory read data.
- `uart_wr` out 1: one-cycle UART write strobe.
- `uart_data` out 8: UART byte.
- `uart_busy` in 1: UART cannot accept a byte.

## Operation
- **States:** IDLE, ACCESS, WAIT, UART, DONE.
- **IDLE:**
  - `d_req` has priority: assert `d_gnt` and capture the request.
  - Otherwise, if `if_req`, assert `if_gnt` and capture the request.
  - Both grants are never high in the same cycle. A losing fetch stays pending.
- **Routing from IDLE:**
  - Misaligned data request (with the macro) → DONE with `d_err`=1.
  - `d_addr == UART_ADDR` → UART.
  - Otherwise → ACCESS.
- **ACCESS:** `mem_en`=1 for exactly one cycle with `mem_addr`/`mem_we`/`mem_wdata` registered. Store → DONE. Load/fetch → WAIT.
- **WAIT:** count `MEM_LATENCY`−1 further cycles, then sample `mem_rdata`, format it, → DONE.
- **UART store:** stay in UART while `uart_busy`=1. On the first cycle with `uart_busy`=0, pulse `uart_wr`=1 with `uart_data = d_wdata[7:0]`, → DONE.
- **UART load:** no wait; `d_rdata = {31'b0, uart_busy}` sampled in the UART cycle, → DONE.
- **DONE:** pulse `if_valid` or `d_valid` for one cycle, → IDLE.
- **Store lanes:**
  - Byte: `mem_we = 0001 << addr[1:0]`, byte replicated to all lanes.
  - Half: `mem_we = 0011 << {addr[1],1'b0}`, half replicated.
  - Word: `mem_we = 1111`.
- **Load extraction:** select the lane by `addr[1:0]`. Sign-extend from bit 7/15 unless `d_unsigned`=1. Word loads pass through unchanged.
- **Misaligned:** half with `addr[0]`=1; word with `addr[1:0]`≠00. Byte accesses are never misaligned.
- **Reset:** state → IDLE; the pending request is discarded with no response. No memory or UART write is issued in or after the reset cycle.
- **Outputs during and after reset:** every output is 0 (`mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 32'h0).

## Timing
- Cycle 0 = grant cycle (IDLE).
- Load/fetch:
  - `mem_en` in cycle 1.
  - `mem_rdata` sampled in cycle `MEM_LATENCY`.
  - `*_valid` in cycle `MEM_LATENCY`+1.
  - Next grant possible in cycle `MEM_LATENCY`+2.
- Memory store: `mem_en`/`mem_we` in cycle 1, `d_valid` in cycle 2.
- UART store with `uart_busy` low: `uart_wr` in cycle 1, `d_valid` in cycle 2. Each busy cycle adds one.
- Misaligned access: `d_valid` and `d_err` in cycle 1; no `mem_en`.
- `*_rdata` and `d_err` hold their values until the next DONE or reset.
- Requesters may change inputs in the cycle after the grant. Requests not held until granted are lost.

## Configuration
- **`MISALIGN_TRAP_EN` defined:** misaligned data requests do not access memory or the UART, and complete with `d_err`=1 and `d_rdata`=0.
- **`MISALIGN_TRAP_EN` undefined:** `d_err` is tied 0. Offending low address bits are forced to zero (half: `addr[0]`; word: `addr[1:0]`) and the access proceeds normally.

## Test plan
- Memory holds 32'h80F0_1234 at 0x100 and `MEM_LATENCY`=1. Byte load from 0x103 with `d_unsigned`=0 → `d_rdata`=32'hFFFF_FF80 and `d_valid` in cycle 2. Repeated with `d_unsigned`=1 → 32'h0000_0080.
- Half store of 32'h0000_ABCD to 0x102 → `mem_we`=1100, `mem_wdata`=32'hABCD_ABCD, `mem_addr`=0x100 in cycle 1, `d_valid` in cycle 2.
- `if_req` and `d_req` both asserted in the same IDLE cycle → `d_gnt`=1 and `if_gnt`=0. The fetch is granted in the first IDLE cycle after `d_valid`.
- Store of 32'h41 to 32'h00020000 with `uart_busy` high for 3 cycles → no `mem_en`, `uart_wr` with `uart_data`=8'h41 in cycle 4, `d_valid` in cycle 5.
- With `MISALIGN_TRAP_EN` defined, word load from 0x102 → `d_valid`=`d_err`=1 in cycle 1, no `mem_en`. Without the macro, the same load reads 0x100 and `d_err`=0.
- `rst` asserted in cycle 1 of a store → no `mem_en`/`uart_wr` and no `d_valid` from that cycle onward; all outputs 0; IDLE grants a new request in the first cycle after `rst` deasserts.
